dcache_responder: RTL



---
 rtl/dcache_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// with 16-byte lines, serving the EXM dcache request bus. It refills lines
// through a single-request read port and writes stores through a single-word
// write port. Define DCACHE_PERF_CNT_EN to add load hit/miss counters.
module dcache_responder #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dcache_valid,
    input  logic              dcache_we,
    input  logic [3:0]        dcache_wstrb,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [31:0]       dcache_wdata,
    output logic              dcache_ready,
    output logic              dcache_rvalid,
    output logic [31:0]       dcache_rdata,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [3:0]        mem_wr_strb,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_ack
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, WRITE} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:2]  addr_q;
    logic               we_q;
    logic [3:0]         strb_q;
    logic [31:0]        wdata_q;
    logic [LINES-1:0]   line_valid;
    logic [TAG_W-1:0]   tag_ram [LINES];
    logic [31:0]        data_ram [LINES*4];
    logic [1:0]         cnt;
    logic [31:0]        capture;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         offset;
    logic               accept, hit, beat, last_beat;
    logic               unused_addr_bits;

    assign index     = addr_q[INDEX_W+3:4];
    assign tag       = addr_q[ADDR_W-1:INDEX_W+4];
    assign offset    = addr_q[3:2];
    assign accept    = dcache_valid & dcache_ready;
    assign hit       = line_valid[index] & (tag_ram[index] == tag);
    // An ack arriving together with the first beat still counts that beat.
    assign beat      = mem_rd_valid & ((state == REFILL) | ((state == MISS_REQ) & mem_rd_ack));
    assign last_beat = beat & (cnt == 2'd3);

    assign mem_rd_addr = {addr_q[ADDR_W-1:4], 4'b0000};
    assign mem_wr_addr = {addr_q, 2'b00};
    assign mem_wr_strb = strb_q;
    assign mem_wr_data = wdata_q;

    assign unused_addr_bits = ^dcache_addr[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-state handshake outputs
    always_comb begin
        state_next   = state;
        dcache_ready = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        case (state)
            IDLE: begin
                dcache_ready = 1'b1;
                if (dcache_valid) state_next = LOOKUP;
            end
            LOOKUP:   state_next = we_q ? WRITE : (hit ? IDLE : MISS_REQ);
            MISS_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) state_next = REFILL;
            end
            REFILL:   if (last_beat) state_next = RESP;
            RESP:     state_next = IDLE;
            WRITE: begin
                mem_wr_req = 1'b1;
                if (mem_wr_ack) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Request latch, tag/data arrays, refill beat accounting and load response
    always_ff @(posedge clk) begin
        if (reset) begin
            line_valid    <= '0;
            cnt           <= '0;
            capture       <= '0;
            dcache_rvalid <= 1'b0;
            dcache_rdata  <= '0;
        end else begin
            dcache_rvalid <= 1'b0;
            if (accept) begin
                addr_q  <= dcache_addr[ADDR_W-1:2];
                we_q    <= dcache_we;
                strb_q  <= dcache_wstrb;
                wdata_q <= dcache_wdata;
            end
            if (state == LOOKUP && !we_q) begin
                if (hit) begin
                    dcache_rvalid <= 1'b1;
                    dcache_rdata  <= data_ram[{index, offset}];
                end else begin
                    // The victim line is overwritten beat by beat, so it must stop hitting now.
                    line_valid[index] <= 1'b0;
                end
            end
            if (state == LOOKUP && we_q && hit) begin
                for (int b = 0; b < 4; b++)
                    if (strb_q[b]) data_ram[{index, offset}][8*b +: 8] <= wdata_q[8*b +: 8];
            end
            if (beat) begin
                data_ram[{index, cnt}] <= mem_rd_data;
                cnt <= cnt + 2'd1;
                if (cnt == offset) capture <= mem_rd_data;
                if (last_beat) begin
                    line_valid[index] <= 1'b1;
                    tag_ram[index]    <= tag;
                    dcache_rvalid     <= 1'b1;
                    dcache_rdata      <= (offset == 2'd3) ? mem_rd_data : capture;
                end
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Load hit/miss counters, decided at tag compare; stores are not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (state == LOOKUP && !we_q) begin
            if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
            else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif

endmodule
